// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, frame width and parity helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_t;

  // Even-parity bit for a data word: XOR of all data bits.
  function automatic logic parity_even(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module   : uart_sync
// Brief    : Two-flop synchronizer for an asynchronous single-bit input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver, 8 data bits, LSB first, 1 stop bit. Even parity
//            bit is added when UART_RX_PARITY_EN is defined (8E1), else 8N1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] C_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST  = BIT_W'(DATA_W - 1);

  logic              w_rx_s;
  uart_state_t       r_state;
  uart_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_frame_err;
  logic              w_half_done;
  logic              w_bit_done;
  logic              w_shift_en;
  logic              w_dv;
  logic              w_fe;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx_in),
    .sync_out (w_rx_s)
  );

  assign w_half_done = (r_cnt == C_HALF_LAST);
  assign w_bit_done  = (r_cnt == C_FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_pe;
  logic w_par_load;
  logic w_par_ok;

  assign w_par_ok = ~(parity_even(r_shift) ^ r_par_bit);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_dv        = 1'b0;
    w_fe        = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pe        = 1'b0;
    w_par_load  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rx_s) w_state_nxt = START;
      end
      // Mid-start resample rejects line glitches shorter than half a bit.
      START: begin
        if (w_half_done) w_state_nxt = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == C_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_par_load  = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          if (w_rx_s) begin
            w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (w_par_ok) w_dv = 1'b1;
            else          w_pe = 1'b1;
`else
            w_dv = 1'b1;
`endif
          end else begin
            w_state_nxt = WAIT_IDLE;
            w_fe        = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data_valid <= w_dv;
      r_frame_err  <= w_fe;

      // Bit timer restarts on every transition and at each data-bit boundary.
      if ((w_state_nxt != r_state) || w_bit_done ||
          (r_state == IDLE) || (r_state == WAIT_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end

      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
      if (w_dv)       r_data_out <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_pe;
      if (w_par_load) r_par_bit <= w_rx_s;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (CLKS_PER_BIT = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + (PAR ? CPB : 0);

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  int         cyc = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         excl_err = 0;
  int         dv_cyc = 0;
  logic       dv_busy = 1'b0;
  logic [7:0] dv_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  = dv_cnt + 1;
      dv_cyc  = cyc;
      dv_busy = busy;
      dv_q.push_back(data_out);
    end
    if (frame_err)  fe_cnt = fe_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
    if ((int'(data_valid) + int'(frame_err) + int'(parity_err)) > 1) excl_err = excl_err + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_bits);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    if (PAR) drive_bit(par, CPB);
    drive_bit(stop, CPB * stop_bits);
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests_run++;
    if (data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data_out: got %h want 00", data_out);
    end
    tests_run++;
    if ({data_valid, frame_err, parity_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_pulses: got %b want 000", {data_valid, frame_err, parity_err});
    end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_8n1();
    int k, dv0, fe0, pe0;
    dv_q.delete();
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    k = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if ((dv_cnt - dv0) !== 1) begin
      tests_failed++;
      $display("FAIL a5_dv_count: got %0d want 1", dv_cnt - dv0);
    end
    tests_run++;
    if (dv_q.size() !== 1 || dv_q[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL a5_data: got %h (n=%0d) want a5", data_out, dv_q.size());
    end
    tests_run++;
    if ((dv_cyc - k) !== LAT) begin
      tests_failed++;
      $display("FAIL a5_latency: got %0d want %0d", dv_cyc - k, LAT);
    end
    tests_run++;
    if (dv_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL a5_busy_at_valid: got %b want 0", dv_busy);
    end
    tests_run++;
    if ((fe_cnt - fe0) !== 0 || (pe_cnt - pe0) !== 0) begin
      tests_failed++;
      $display("FAIL a5_err_pulses: got fe=%0d pe=%0d want 0 0", fe_cnt - fe0, pe_cnt - pe0);
    end
  endtask

  task automatic test_glitch();
    int dv0, fe0, pe0, t_start, t_end;
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    t_start = -1; t_end = -1;
    rx_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 3) rx_in = 1'b1;
      if (busy && t_start < 0) t_start = i;
      if (!busy && t_start >= 0 && t_end < 0) t_end = i;
    end
    tests_run++;
    if (t_start < 0 || t_end < 0) begin
      tests_failed++;
      $display("FAIL glitch_busy_seen: got start=%0d end=%0d want both >= 0", t_start, t_end);
    end
    tests_run++;
    if ((t_end - t_start) > 8) begin
      tests_failed++;
      $display("FAIL glitch_busy_len: got %0d want <= 8", t_end - t_start);
    end
    tests_run++;
    if ((dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin
      tests_failed++;
      $display("FAIL glitch_pulses: got %0d want 0", (dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0));
    end
  endtask

  task automatic test_frame_error();
    int fe0;
    dv_q.delete();
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    repeat (2 * CPB) tick();
    tests_run++;
    if ((fe_cnt - fe0) !== 1) begin
      tests_failed++;
      $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0);
    end
    tests_run++;
    if (data_out !== 8'hA5 || dv_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL ferr_data_hold: got %h (n=%0d) want a5 (n=1)", data_out, dv_q.size());
    end
    send_frame(8'h5A, ^8'h5A, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if (dv_q.size() !== 2 || dv_q[1] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL ferr_next_frame: got %h (n=%0d) want 5a (n=2)", data_out, dv_q.size());
    end
  endtask

  task automatic test_back_to_back();
    dv_q.delete();
    send_frame(8'h00, 1'b0, 1'b1, 1);
    send_frame(8'hFF, 1'b0, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if (dv_q.size() !== 2 || dv_q[0] !== 8'h00 || dv_q[1] !== 8'hFF) begin
      tests_failed++;
      $display("FAIL b2b_data: got n=%0d first=%h second=%h want n=2 00 ff", dv_q.size(), dv_q[0], dv_q[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0, pe0;
    logic [7:0] d;
    dv_q.delete();
    dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    d = 8'h81;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(d[i], CPB);
    drive_bit(d[3], CPB / 2);
    rst   = 1'b1;
    rx_in = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got busy=%b data=%h want 0 00", busy, data_out);
    end
    repeat (2 * CPB) tick();
    tests_run++;
    if ((dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0) !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_pulses: got %0d busy=%b want 0 0", (dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0), busy);
    end
    send_frame(8'h55, ^8'h55, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if (dv_q.size() !== 1 || dv_q[0] !== 8'h55) begin
      tests_failed++;
      $display("FAIL rst_mid_next: got %h (n=%0d) want 55 (n=1)", data_out, dv_q.size());
    end
  endtask

  task automatic test_parity();
    int dv0, pe0;
    dv_q.delete();
    dv0 = dv_cnt; pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if ((pe_cnt - pe0) !== 1 || (dv_cnt - dv0) !== 0) begin
      tests_failed++;
      $display("FAIL parity_bad: got pe=%0d dv=%0d want 1 0", pe_cnt - pe0, dv_cnt - dv0);
    end
    send_frame(8'h07, 1'b1, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if (dv_q.size() !== 1 || dv_q[0] !== 8'h07 || (pe_cnt - pe0) !== 1) begin
      tests_failed++;
      $display("FAIL parity_good: got %h (n=%0d) pe=%0d want 07 (n=1) 1", data_out, dv_q.size(), pe_cnt - pe0);
    end
`else
    send_frame(8'h07, 1'b0, 1'b1, 1);
    repeat (4) tick();
    tests_run++;
    if (pe_cnt !== 0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_tied: got pe=%0d want 0", pe_cnt);
    end
    tests_run++;
    if (dv_q.size() !== 1 || dv_q[0] !== 8'h07 || (dv_cnt - dv0) !== 1) begin
      tests_failed++;
      $display("FAIL nopar_07: got %h (n=%0d) want 07 (n=1)", data_out, dv_q.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    tests_run++;
    if (excl_err !== 0) begin
      tests_failed++;
      $display("FAIL pulse_exclusive: got %0d overlaps want 0", excl_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
